// File: rtl/slow_pulse_pkg.sv
// Shared mode encodings and reset defaults for the slow-domain pulse generator.
package slow_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_PULSE   = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int DEF_PERIOD_C = 16;
  localparam int DEF_HIT_C    = 9;

  // The reserved encoding behaves exactly like periodic pulse mode.
  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_PULSE : mode_e'(m);
  endfunction

endpackage

// File: rtl/slow_pulse_gen_ch.sv
// One compare channel: matches the period counter against its hit value and
// produces either a one-cycle pulse or a toggling level.
module slow_pulse_ch
  import slow_pulse_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk1,
  input  logic             rstn,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] hit_val,
  input  logic             running,
  input  mode_e            mode,
  output logic             sig
);

  logic hit;
  logic sig_d;
  logic sig_q;

  always_comb begin
    hit   = running && (cnt == hit_val);
    sig_d = hit;
    // Toggle levels survive idle periods; only reset clears them.
    if (mode == MODE_TOGGLE) begin
      sig_d = sig_q ^ hit;
    end
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/slow_pulse_gen.sv
// Programmable period counter with NUM_CH compare channels, config shadowing
// and one-shot control; source-side stimulus for CDC synchroniser bring-up.
module slow_pulse_gen
  import slow_pulse_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int NUM_CH     = 2,
  parameter int DEF_PERIOD = DEF_PERIOD_C,
  parameter int DEF_HIT    = DEF_HIT_C
) (
  input  logic                    clk1,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    start,
  input  logic [CNT_W-1:0]        period_cfg,
  input  logic [NUM_CH*CNT_W-1:0] hit_cfg,
  output logic [NUM_CH-1:0]       sig,
  output logic                    wrap,
  output logic                    busy,
  output logic                    done
);

  logic [CNT_W-1:0]             cnt_d, cnt_q;
  logic [CNT_W-1:0]             period_sh_d, period_sh_q;
  logic [NUM_CH-1:0][CNT_W-1:0] hit_sh_d, hit_sh_q;
  mode_e                        mode_sh_d, mode_sh_q;
  logic                         busy_d, busy_q;
  logic                         done_d, done_q;
  logic                         wrap_d, wrap_q;
  logic                         running;
  logic                         terminal;
  logic                         load;

  always_comb begin
    running  = (mode_sh_q == MODE_ONESHOT) ? (busy_q && en) : en;
    terminal = running && (cnt_q == period_sh_q);
    // Config is only taken while idle or at a period boundary, so a running
    // period never sees a half-applied configuration.
    load     = !running || terminal;

    cnt_d       = (running && !terminal) ? cnt_q + 1'b1 : '0;
    period_sh_d = load ? period_cfg : period_sh_q;
    hit_sh_d    = load ? hit_cfg : hit_sh_q;
    mode_sh_d   = load ? decode_mode(mode) : mode_sh_q;

    wrap_d = terminal;
    done_d = terminal && (mode_sh_q == MODE_ONESHOT);

    busy_d = busy_q;
    if (!en || done_d) begin
      busy_d = 1'b0;
    end else if ((mode == 2'b10) && start && !busy_q) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      period_sh_q <= CNT_W'(DEF_PERIOD - 1);
      hit_sh_q    <= {NUM_CH{CNT_W'(DEF_HIT)}};
      mode_sh_q   <= MODE_PULSE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      hit_sh_q    <= hit_sh_d;
      mode_sh_q   <= mode_sh_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    slow_pulse_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk1    (clk1),
      .rstn    (rstn),
      .cnt     (cnt_q),
      .hit_val (hit_sh_q[gi]),
      .running (running),
      .mode    (mode_sh_q),
      .sig     (sig[gi])
    );
  end

  assign wrap = wrap_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_slow_pulse_gen.sv
// Self-checking bench for slow_pulse_gen: directed scenarios with fixed edge
// expectations plus a randomized run against an integer reference model.
module tb_slow_pulse_gen;

  localparam int CNT_W  = 4;
  localparam int NUM_CH = 2;

  logic                    clk1 = 1'b0;
  logic                    rstn = 1'b0;
  logic                    en = 1'b1;
  logic [1:0]              mode = 2'b00;
  logic                    start = 1'b0;
  logic [CNT_W-1:0]        period_cfg = 4'd15;
  logic [NUM_CH*CNT_W-1:0] hit_cfg = {4'd9, 4'd9};
  logic [NUM_CH-1:0]       sig;
  logic                    wrap;
  logic                    busy;
  logic                    done;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // Reference model state: position within the current period, latched config.
  int m_pos;
  int m_per;
  int m_hit[NUM_CH];
  int m_mode;
  bit m_busy;
  logic [NUM_CH-1:0] e_sig;
  logic e_wrap;
  logic e_done;

  slow_pulse_gen #(
    .CNT_W(CNT_W),
    .NUM_CH(NUM_CH),
    .DEF_PERIOD(16),
    .DEF_HIT(9)
  ) dut (
    .clk1       (clk1),
    .rstn       (rstn),
    .en         (en),
    .mode       (mode),
    .start      (start),
    .period_cfg (period_cfg),
    .hit_cfg    (hit_cfg),
    .sig        (sig),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_per  = 15;
    m_mode = 0;
    m_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_hit[i] = 9;
    e_sig  = '0;
    e_wrap = 1'b0;
    e_done = 1'b0;
  endtask

  task automatic model_edge();
    bit active;
    bit last;
    bit h;
    active = (m_mode == 2) ? (m_busy && en) : en;
    last   = active && (m_pos == m_per);
    for (int i = 0; i < NUM_CH; i++) begin
      h = active && (m_pos == m_hit[i]);
      e_sig[i] = (m_mode == 1) ? (e_sig[i] ^ h) : h;
    end
    e_wrap = last;
    e_done = last && (m_mode == 2);
    if (!en || e_done) m_busy = 1'b0;
    else if (mode == 2'b10 && start) m_busy = 1'b1;
    m_pos = (active && !last) ? m_pos + 1 : 0;
    if (!active || last) begin
      m_per  = int'(period_cfg);
      for (int i = 0; i < NUM_CH; i++) m_hit[i] = int'(hit_cfg[i*CNT_W +: CNT_W]);
      m_mode = (mode == 2'b11) ? 0 : int'(mode);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    model_edge();
    edge_n++;
    #1;
    $display("[TB] edge=%0d en=%b mode=%0d start=%b sig=%b wrap=%b busy=%b done=%b",
             edge_n, en, mode, start, sig, wrap, busy, done);
    check("model_sig", sig, e_sig);
    check("model_wrap", wrap, e_wrap);
    check("model_busy", busy, m_busy);
    check("model_done", done, e_done);
  endtask

  initial begin
    int toggles;
    int busy_cnt;
    int done_cnt;
    logic prev;

    model_reset();
    #12;
    check("reset_sig", sig, 0);
    check("reset_wrap", wrap, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rstn = 1'b1;

    // Legacy behaviour, then a mid-period reconfiguration of period and ch1.
    for (int k = 0; k < 70; k++) begin
      step();
      check("legacy_sig0", sig[0], edge_n inside {10, 26, 42});
      check("legacy_sig1", sig[1], edge_n inside {10, 26, 42, 52, 60, 68});
      check("legacy_wrap", wrap, edge_n inside {16, 32, 48, 56, 64});
      if (edge_n == 36) begin
        period_cfg = 4'd7;
        hit_cfg    = {4'd3, 4'd9};
      end
    end

    // Toggle mode, period 4, hit 2: three toggles then hold with en low.
    en = 1'b0;
    mode = 2'b01;
    period_cfg = 4'd4;
    hit_cfg = {4'd2, 4'd2};
    repeat (3) step();
    en = 1'b1;
    toggles = 0;
    prev = sig[0];
    for (int k = 0; k < 15; k++) begin
      step();
      if (sig[0] !== prev) toggles++;
      prev = sig[0];
    end
    check("toggle_count", toggles, 3);
    en = 1'b0;
    repeat (3) step();
    check("toggle_hold", sig, 2'b11);

    // One-shot, period 5: six busy cycles, a single done, second start ignored.
    mode = 2'b10;
    period_cfg = 4'd5;
    hit_cfg = {4'd3, 4'd1};
    repeat (2) step();
    en = 1'b1;
    repeat (2) step();
    check("oneshot_idle_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = int'(busy);
    done_cnt = int'(done);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) start = 1'b1;
      step();
      if (k == 2) start = 1'b0;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    check("oneshot_busy_cycles", busy_cnt, 6);
    check("oneshot_done_count", done_cnt, 1);

    // Abort: en drops with the counter at 2.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    en = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("abort_sig", sig, 0);
      check("abort_no_done", done, 0);
    end

    // Start coincident with en falling: abort wins.
    en = 1'b1;
    step();
    start = 1'b1;
    en = 1'b0;
    step();
    start = 1'b0;
    check("start_vs_abort", busy, 0);

    // Period 0: ch0 (hit 0) held high, ch1 (hit 1) never fires, wrap held high.
    mode = 2'b00;
    period_cfg = 4'd0;
    hit_cfg = {4'd1, 4'd0};
    repeat (2) step();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("p0_sig", sig, 2'b01);
      check("p0_wrap", wrap, 1);
    end

    // Randomized run against the reference model.
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 15) != 0);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        period_cfg = 4'($urandom_range(0, 15));
        hit_cfg = 8'($urandom_range(0, 255));
      end
      step();
    end

    // Asynchronous reset mid-period, then legacy timing from a clean start.
    rstn = 1'b0;
    #2;
    check("areset_sig", sig, 0);
    check("areset_wrap", wrap, 0);
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    model_reset();
    en = 1'b1;
    mode = 2'b00;
    start = 1'b0;
    period_cfg = 4'd15;
    hit_cfg = {4'd9, 4'd9};
    #2;
    rstn = 1'b1;
    edge_n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("restart_sig0", sig[0], edge_n == 10);
      check("restart_wrap", wrap, edge_n == 16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
